// File: rtl/wait_state_mem_pkg.sv
// Shared types and constants for the wait-state memory model.
package wait_state_mem_pkg;

  localparam int WORD_W   = 32;
  localparam int BE_W     = WORD_W / 8;
  localparam int ERR_W    = 16;
  localparam int ERR_USED = 6;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Bit positions inside errcode
  localparam int ERR_RW_BOTH  = 0;
  localparam int ERR_DROP     = 1;
  localparam int ERR_ADDR_CHG = 2;
  localparam int ERR_DATA_CHG = 3;
  localparam int ERR_MISALIGN = 4;
  localparam int ERR_RANGE    = 5;

endpackage

// File: rtl/wait_state_mem_if.sv
// Request/response bus between a memory requester and the wait-state memory.
interface wait_state_mem_if;
  import wait_state_mem_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [BE_W-1:0]   mem_byte_enable;
  logic [31:0]       mem_address;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [WORD_W-1:0] mem_rdata;
  logic [ERR_W-1:0]  errcode;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, errcode
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata, errcode
  );

endinterface

// File: rtl/wait_state_mem_array.sv
// Single-port word array with byte-lane write enables and a registered read.
module wait_state_mem_array
  import wait_state_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic                  rd_zero_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [WORD_W-1:0] rdata_q;

  // Byte-lane writes; lanes with a cleared enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  // Read register only moves on a read, so it holds across later writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= rd_zero_i ? '0 : mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wait_state_mem.sv
// Wait-state memory: latches a request, counts LATENCY cycles, then performs
// the access and pulses mem_resp; protocol violations go to sticky errcode.
module wait_state_mem
  import wait_state_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  wait_state_mem_if.slave bus
);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_q;
  logic [31:0]         addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic                resp_q;
  logic [ERR_USED-1:0] err_q;

  logic dropped, in_range, access;

  // Requested op no longer held by the requester.
  assign dropped  = wr_q ? !bus.mem_write : !bus.mem_read;
  assign in_range = (addr_q >> (DEPTH_LOG2 + 2)) == '0;
  assign access   = (state_q == BUSY) && !dropped && (cnt_q == '0);

  // Control FSM: IDLE latches, BUSY counts and checks stability, RESP pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      resp_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          if (bus.mem_read && bus.mem_write) begin
            err_q[ERR_RW_BOTH] <= 1'b1;
          end else if (bus.mem_read || bus.mem_write) begin
            wr_q    <= bus.mem_write;
            addr_q  <= bus.mem_address;
            wdata_q <= bus.mem_wdata;
            be_q    <= bus.mem_byte_enable;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_address != addr_q) err_q[ERR_ADDR_CHG] <= 1'b1;
          if (wr_q && (bus.mem_wdata != wdata_q || bus.mem_byte_enable != be_q))
            err_q[ERR_DATA_CHG] <= 1'b1;
          if (dropped) begin
            err_q[ERR_DROP] <= 1'b1;
            state_q         <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (addr_q[1:0] != 2'b00) err_q[ERR_MISALIGN] <= 1'b1;
            if (!in_range)            err_q[ERR_RANGE]    <= 1'b1;
            resp_q  <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  wait_state_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (access && wr_q && in_range),
    .be_i      (be_q),
    .addr_i    (addr_q[DEPTH_LOG2+1:2]),
    .wdata_i   (wdata_q),
    .re_i      (access && !wr_q),
    .rd_zero_i (!in_range),
    .rdata_o   (bus.mem_rdata)
  );

  assign bus.mem_resp = resp_q;
  assign bus.errcode  = {{(ERR_W-ERR_USED){1'b0}}, err_q};

endmodule

// File: tb/tb_wait_state_mem.sv
// Scoreboard bench for wait_state_mem with LATENCY=4, DEPTH_LOG2=10.
module tb_wait_state_mem;
  import wait_state_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wait_state_mem_if bus();

  wait_state_mem #(.DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          resp_seen = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every resp pops one expectation; reads check new data, writes
  // check that the read register was left alone.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.mem_resp === 1'b1) begin
      resp_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got resp with rdata 0x%08h want no resp", bus.mem_rdata);
      end else begin
        e = sb.pop_front();
        check(e.name, bus.mem_rdata, e.data);
      end
    end
  end

  // Issue one request and hold it until resp; optionally move the address
  // one cycle after the sample edge.
  task automatic do_op(input string name, input bit rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rd, input bit chg, input logic [31:0] alt);
    exp_t e;
    int   k;
    bit   got;
    if (rd) last_rd = exp_rd;
    e.name = name;
    e.data = last_rd;
    sb.push_back(e);
    @(negedge clk);
    bus.mem_read        = rd;
    bus.mem_write       = !rd;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = be;
    k = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_resp === 1'b1) got = 1;
      else k++;
      if (chg && k == 1) bus.mem_address = alt;
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    check({name, "_latency"}, got ? 32'(k) : 32'hFFFF_FFFF, 32'd4);
    @(posedge clk);
    @(negedge clk);
    check({name, "_pulse_end"}, 32'(bus.mem_resp), 32'd0);
  endtask

  initial begin
    int r0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_resp",  32'(bus.mem_resp), 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'h0);
    check("rst_err",   32'(bus.errcode), 32'h0);

    // Full write, read, partial write, restore
    do_op("wr_full",  0, 32'h10, 32'hDEADBEEF, 4'b1111, '0, 0, '0);
    do_op("rd_full",  1, 32'h10, '0, '0, 32'hDEADBEEF, 0, '0);
    do_op("wr_part",  0, 32'h10, 32'h11223344, 4'b0101, '0, 0, '0);
    do_op("rd_part",  1, 32'h10, '0, '0, 32'hDE22BE44, 0, '0);
    do_op("wr_rest",  0, 32'h10, 32'hDEADBEEF, 4'b1111, '0, 0, '0);
    do_op("wr_14",    0, 32'h14, 32'hCAFEF00D, 4'b1111, '0, 0, '0);
    do_op("wr_noop",  0, 32'h14, 32'h00000000, 4'b0000, '0, 0, '0);
    do_op("rd_14",    1, 32'h14, '0, '0, 32'hCAFEF00D, 0, '0);

    // Read and write together
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_address = 32'h20;
    r0 = resp_seen;
    repeat (20) @(negedge clk);
    check("both_noresp", 32'(resp_seen - r0), 32'd0);
    check("both_err",    32'(bus.errcode), 32'h0001);
    check("both_idle",   32'(dut.state_q), 32'(IDLE));
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;

    // Read dropped two cycles in
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.mem_address = 32'h10;
    r0 = resp_seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.mem_read = 1'b0;
    repeat (10) @(negedge clk);
    check("drop_noresp", 32'(resp_seen - r0), 32'd0);
    check("drop_err",    32'(bus.errcode), 32'h0003);
    do_op("rd_after_drop", 1, 32'h10, '0, '0, 32'hDEADBEEF, 0, '0);

    // Address moved mid-read: data still from 0x14
    do_op("rd_addr_chg", 1, 32'h14, '0, '0, 32'hCAFEF00D, 1, 32'h10);
    check("addr_chg_err", 32'(bus.errcode), 32'h0007);

    // Reset during BUSY discards the write
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.mem_address = 32'h10;
    bus.mem_wdata = 32'h0;
    bus.mem_byte_enable = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    r0 = resp_seen;
    repeat (10) @(negedge clk);
    check("rstmid_noresp", 32'(resp_seen - r0), 32'd0);
    check("rstmid_err",    32'(bus.errcode), 32'h0000);
    check("rstmid_rdata",  bus.mem_rdata, 32'h0);
    check("rstmid_idle",   32'(dut.state_q), 32'(IDLE));
    do_op("rd_after_rst", 1, 32'h10, '0, '0, 32'hDEADBEEF, 0, '0);

    // Out of range and misaligned
    do_op("rd_oor", 1, 32'h00100000, '0, '0, 32'h0, 0, '0);
    check("oor_err", 32'(bus.errcode), 32'h0020);
    do_op("wr_oor", 0, 32'h00100010, 32'h12345678, 4'b1111, '0, 0, '0);
    do_op("rd_after_oor", 1, 32'h10, '0, '0, 32'hDEADBEEF, 0, '0);
    do_op("rd_misalign",  1, 32'h12, '0, '0, 32'hDEADBEEF, 0, '0);
    check("misalign_err", 32'(bus.errcode), 32'h0030);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
